// File: rtl/hex_disp_sched.sv
// rtl/hex_disp_sched.sv - update scheduler sharing one BCD-to-seven-segment decoder across NUM_DIG digits
// Optional leading-zero blanking: define HEX_DISP_SCHED_LZB_EN.
module hex_disp_sched #(
   parameter int NUM_DIG = 4,
   parameter int IDX_W   = 3
) (
   input  logic                 CLOCK_50,
   input  logic                 RST,
   input  logic                 LD_VALID,
   output logic                 LD_READY,
   input  logic [4*NUM_DIG-1:0] LD_DATA,
   output logic [3:0]           DEC_IN,
   input  logic [6:0]           DEC_OUT,
   output logic [7*NUM_DIG-1:0] HEX,
   output logic                 BUSY,
   output logic                 UPD_DONE,
   output logic                 BAD_DIG
);

   typedef enum logic [1:0] {IDLE, SET, CAP, DONE} state_t;

   state_t               state_q, state_d;
   logic [4*NUM_DIG-1:0] shadow_q;
   logic [IDX_W-1:0]     idx_q;
   logic [3:0]           dec_hold_q;
   logic [7*NUM_DIG-1:0] hex_q;
   logic                 bad_acc_q;
   logic                 bad_q;

   logic                 accept;
   logic                 last_dig;
   logic [3:0]           cur_code;
   logic                 cur_bad;
   logic                 cur_blank;
   logic [6:0]           cap_seg;

   assign accept   = LD_VALID && (state_q == IDLE);
   assign last_dig = (idx_q == IDX_W'(NUM_DIG - 1));

   always_comb begin
      cur_code = 4'h0;
      for (int i = 0; i < NUM_DIG; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_code = shadow_q[4*i +: 4];
         end
      end
   end

   assign cur_bad = (cur_code > 4'd9);

`ifdef HEX_DISP_SCHED_LZB_EN
   logic [NUM_DIG-1:0] blank_d, blank_q;
   logic               lzb_run;

   // Zero run is measured from the top digit down; digit 0 always shows.
   always_comb begin
      blank_d = '0;
      lzb_run = 1'b1;
      for (int i = NUM_DIG - 1; i >= 1; i--) begin
         lzb_run    = lzb_run & (LD_DATA[4*i +: 4] == 4'h0);
         blank_d[i] = lzb_run;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         blank_q <= '0;
      end else if (accept) begin
         blank_q <= blank_d;
      end
   end

   always_comb begin
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIG; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_blank = blank_q[i];
         end
      end
   end
`else
   assign cur_blank = 1'b0;
`endif

   // The decoder output is undefined above 9, so it is never captured there.
   assign cap_seg = (cur_bad || cur_blank) ? 7'h7F : DEC_OUT;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (LD_VALID) state_d = SET;
         SET:     state_d = CAP;
         CAP:     state_d = last_dig ? DONE : SET;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         idx_q      <= '0;
         dec_hold_q <= 4'h0;
         hex_q      <= {NUM_DIG{7'h7F}};
         bad_acc_q  <= 1'b0;
         bad_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            shadow_q  <= LD_DATA;
            bad_acc_q <= 1'b0;
            idx_q     <= '0;
         end
         if (state_q == CAP) begin
            dec_hold_q <= cur_code;
            for (int i = 0; i < NUM_DIG; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  hex_q[7*i +: 7] <= cap_seg;
               end
            end
            if (cur_bad) begin
               bad_acc_q <= 1'b1;
            end
            if (!last_dig) begin
               idx_q <= idx_q + 1'b1;
            end
         end
         if (state_q == DONE) begin
            bad_q <= bad_acc_q;
         end
      end
   end

   assign LD_READY = (state_q == IDLE);
   assign BUSY     = (state_q != IDLE);
   assign UPD_DONE = (state_q == DONE);
   assign DEC_IN   = ((state_q == SET) || (state_q == CAP)) ? cur_code : dec_hold_q;
   assign HEX      = hex_q;
   assign BAD_DIG  = bad_q;

endmodule

// File: tb/tb_hex_disp_sched.sv
// tb/tb_hex_disp_sched.sv - directed self-checking bench for hex_disp_sched
// Honours HEX_DISP_SCHED_LZB_EN for the expected blanked patterns.
module tb_hex_disp_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid;
   logic        ld_ready;
   logic [15:0] ld_data;
   logic [3:0]  dec_in;
   logic [6:0]  dec_out;
   logic [27:0] hex;
   logic        busy;
   logic        upd_done;
   logic        bad_dig;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [27:0] cur_hex;
   logic        cur_bad;

   localparam logic [27:0] P_BLANK = {4{7'h7F}};
   localparam logic [27:0] P_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
   localparam logic [27:0] P_5678  = {7'h12, 7'h02, 7'h78, 7'h00};
`ifdef HEX_DISP_SCHED_LZB_EN
   localparam logic [27:0] P_0A07  = {7'h7F, 7'h7F, 7'h40, 7'h78};
   localparam logic [27:0] P_0000  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [27:0] P_0040  = {7'h7F, 7'h7F, 7'h19, 7'h40};
`else
   localparam logic [27:0] P_0A07  = {7'h40, 7'h7F, 7'h40, 7'h78};
   localparam logic [27:0] P_0000  = {7'h40, 7'h40, 7'h40, 7'h40};
   localparam logic [27:0] P_0040  = {7'h40, 7'h40, 7'h19, 7'h40};
`endif

   always #10 clk = ~clk;

   // Shared decoder: active-low segments, undefined above 9.
   always_comb begin
      case (dec_in)
         4'd0:    dec_out = 7'h40;
         4'd1:    dec_out = 7'h79;
         4'd2:    dec_out = 7'h24;
         4'd3:    dec_out = 7'h30;
         4'd4:    dec_out = 7'h19;
         4'd5:    dec_out = 7'h12;
         4'd6:    dec_out = 7'h02;
         4'd7:    dec_out = 7'h78;
         4'd8:    dec_out = 7'h00;
         4'd9:    dec_out = 7'h10;
         default: dec_out = 7'bxxxxxxx;
      endcase
   end

   hex_disp_sched #(.NUM_DIG(4), .IDX_W(3)) dut (
      .CLOCK_50 (clk),
      .RST      (rst),
      .LD_VALID (ld_valid),
      .LD_READY (ld_ready),
      .LD_DATA  (ld_data),
      .DEC_IN   (dec_in),
      .DEC_OUT  (dec_out),
      .HEX      (hex),
      .BUSY     (busy),
      .UPD_DONE (upd_done),
      .BAD_DIG  (bad_dig)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Accept one word at the next edge and track every cycle through to IDLE.
   task automatic load_and_check(input string tag, input logic [15:0] data,
                                 input logic [27:0] exp_new, input logic exp_bad);
      logic [27:0] exp;
      check({tag, " ready_before"}, {31'd0, ld_ready}, 32'd1);
      ld_valid = 1'b1;
      ld_data  = data;
      step();
      ld_valid = 1'b0;
      ld_data  = ~data;
      check({tag, " busy_t1"}, {31'd0, busy}, 32'd1);
      check({tag, " ready_t1"}, {31'd0, ld_ready}, 32'd0);
      check({tag, " dec_in_t1"}, {28'd0, dec_in}, {28'd0, data[3:0]});
      for (int k = 2; k <= 10; k++) begin
         step();
         exp = cur_hex;
         for (int i = 0; i < 4; i++) begin
            if (k >= 3 + 2*i) exp[7*i +: 7] = exp_new[7*i +: 7];
         end
         check($sformatf("%s hex_t%0d", tag, k), {4'd0, hex}, {4'd0, exp});
         check($sformatf("%s done_t%0d", tag, k), {31'd0, upd_done}, {31'd0, (k == 9)});
         check($sformatf("%s ready_t%0d", tag, k), {31'd0, ld_ready}, {31'd0, (k == 10)});
         check($sformatf("%s bad_t%0d", tag, k), {31'd0, bad_dig},
               {31'd0, (k == 10) ? exp_bad : cur_bad});
      end
      cur_hex = exp_new;
      cur_bad = exp_bad;
   endtask

   initial begin
      logic seen;
      rst      = 1'b1;
      ld_valid = 1'b0;
      ld_data  = 16'h0;
      cur_hex  = P_BLANK;
      cur_bad  = 1'b0;
      step(); step(); step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("reset hex", {4'd0, hex}, {4'd0, P_BLANK});
      check("reset ready", {31'd0, ld_ready}, 32'd1);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset bad", {31'd0, bad_dig}, 32'd0);
      check("reset done", {31'd0, upd_done}, 32'd0);
      check("reset dec_in", {28'd0, dec_in}, 32'd0);

      load_and_check("ld1234", 16'h1234, P_1234, 1'b0);
      check("idle dec_in hold", {28'd0, dec_in}, 32'd1);

      // Requester holds the second word throughout the first update.
      ld_valid = 1'b1;
      ld_data  = 16'h1234;
      step();
      ld_data = 16'h5678;
      for (int k = 2; k <= 10; k++) begin
         step();
         check($sformatf("b2b ready_t%0d", k), {31'd0, ld_ready}, {31'd0, (k == 10)});
         if (k == 9) begin
            check("b2b first_hex", {4'd0, hex}, {4'd0, P_1234});
            check("b2b first_done", {31'd0, upd_done}, 32'd1);
         end
      end
      step();
      ld_valid = 1'b0;
      check("b2b second_busy", {31'd0, busy}, 32'd1);
      check("b2b second_dec_in", {28'd0, dec_in}, 32'd8);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         seen = upd_done;
      end
      check("b2b done_seen", {31'd0, seen}, 32'd1);
      check("b2b second_hex", {4'd0, hex}, {4'd0, P_5678});
      step();
      check("b2b idle_ready", {31'd0, ld_ready}, 32'd1);
      cur_hex = P_5678;

      load_and_check("ld0A07", 16'h0A07, P_0A07, 1'b1);
      load_and_check("ld0000", 16'h0000, P_0000, 1'b0);
      load_and_check("ld0040", 16'h0040, P_0040, 1'b0);
      load_and_check("ld0A07b", 16'h0A07, P_0A07, 1'b1);

      // Abort in the capture cycle of digit 2.
      ld_valid = 1'b1;
      ld_data  = 16'h9999;
      step();
      ld_valid = 1'b0;
      for (int k = 2; k <= 6; k++) step();
      check("abort pre_hex", {4'd0, hex}, {4'd0, cur_hex[27:14], 7'h10, 7'h10});
      check("abort pre_dec_in", {28'd0, dec_in}, 32'd9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort hex", {4'd0, hex}, {4'd0, P_BLANK});
      check("abort ready", {31'd0, ld_ready}, 32'd1);
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, upd_done}, 32'd0);
      check("abort bad", {31'd0, bad_dig}, 32'd0);
      check("abort dec_in", {28'd0, dec_in}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("abort quiet_done_%0d", k), {31'd0, upd_done}, 32'd0);
         check($sformatf("abort quiet_hex_%0d", k), {4'd0, hex}, {4'd0, P_BLANK});
      end
      cur_hex = P_BLANK;
      cur_bad = 1'b0;

      load_and_check("ld1234b", 16'h1234, P_1234, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
